conv_fetch_ctrl: RTL

Sequencer for the 1-D convolution core. It walks the output index n = 0 .. Nx+Nh-2 and, for each n, drives the address ports of the x and h coefficient ROMs with every valid index pair (k, n-k). It retimes the ROM outputs, which have one cycle of read latency, into a tagged operand stream for the downstream MAC. It sits between the top-level start/done control and the two `rom_sync` instances.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_index_gen.sv | 81 ++++++++
 rtl/conv_fetch_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution controllers.
package conv_pkg;

   // Fetch sequencer states: wait for start, issue pairs, wait for the
   // last ROM read, then pulse completion.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/conv_index_gen.sv
// Output/tap index walker for the 1-D convolution.
// n is the output index and k the x index. For each n, k runs from
// kmin = max(0, n-Nh+1) to kmax = min(n, Nx-1). The h index is n-k.
module conv_index_gen #(
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     step,
   input  logic [ADDRESS_WIDTH:0]   size_x,
   input  logic [ADDRESS_WIDTH:0]   size_h,
   output logic [ADDRESS_WIDTH:0]   n,
   output logic [ADDRESS_WIDTH-1:0] x_index,
   output logic [ADDRESS_WIDTH-1:0] h_index,
   output logic                     is_first,
   output logic                     is_last_k,
   output logic                     is_last_n
);

   localparam int AW = ADDRESS_WIDTH;
   localparam logic [AW:0]   ONE = 1;
   localparam logic [AW+1:0] TWO = 2;

   logic [AW:0]   n_reg;
   logic [AW:0]   k_reg;
   logic [AW:0]   n_inc;
   logic [AW:0]   kmin;
   logic [AW:0]   kmin_inc;
   logic [AW:0]   kmax;
   logic [AW+1:0] n_final;

   // Compare before subtracting so small n never wraps below zero.
   function automatic logic [AW:0] kmin_of(input logic [AW:0] idx,
                                           input logic [AW:0] nh);
      if (idx >= nh)
         return idx - nh + ONE;
      else
         return '0;
   endfunction

   // Window bounds for the current output and the one after it.
   always_comb begin
      n_inc    = n_reg + ONE;
      kmin     = kmin_of(n_reg, size_h);
      kmin_inc = kmin_of(n_inc, size_h);
      kmax     = (n_reg < size_x) ? n_reg : (size_x - ONE);
      // Nx+Nh can reach 2**(AW+1), so the final index needs one extra bit.
      n_final  = {1'b0, size_x} + {1'b0, size_h} - TWO;
   end

   // Position flags and ROM indices.
   always_comb begin
      is_first  = (k_reg == kmin);
      is_last_k = (k_reg == kmax);
      is_last_n = ({1'b0, n_reg} == n_final);
      n         = n_reg;
      x_index   = k_reg[AW-1:0];
      // n-k is always in 0..Nh-1, so modular low-bit subtraction is exact.
      h_index   = n_reg[AW-1:0] - k_reg[AW-1:0];
   end

   // Advance k within an output; at kmax move to the next n and reload kmin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_reg <= '0;
         k_reg <= '0;
      end else if (load) begin
         n_reg <= '0;
         k_reg <= '0;
      end else if (step) begin
         if (is_last_k) begin
            n_reg <= n_inc;
            k_reg <= kmin_inc;
         end else begin
            k_reg <= k_reg + ONE;
         end
      end
   end

endmodule

// File: rtl/conv_fetch_ctrl.sv
// Convolution fetch sequencer: drives x/h ROM addresses for every (k, n-k)
// pair and retimes the pair tags to line up with the one-cycle ROM data.
module conv_fetch_ctrl
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH:0]   size_x,
   input  logic [ADDRESS_WIDTH:0]   size_h,
   output logic [ADDRESS_WIDTH-1:0] addr_x,
   output logic [ADDRESS_WIDTH-1:0] addr_h,
   input  logic [DATA_WIDTH-1:0]    x_data,
   input  logic [DATA_WIDTH-1:0]    h_data,
   output logic                     pair_valid,
   output logic [DATA_WIDTH-1:0]    pair_x,
   output logic [DATA_WIDTH-1:0]    pair_h,
   output logic                     pair_first,
   output logic                     pair_last,
   output logic [ADDRESS_WIDTH:0]   out_index,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = ADDRESS_WIDTH;

   fetch_state_t state;
   fetch_state_t state_next;

   logic [AW:0]   nx_reg;
   logic [AW:0]   nh_reg;
   logic          sizes_zero;
   logic          load;
   logic          step;

   logic [AW:0]   n;
   logic [AW-1:0] x_index;
   logic [AW-1:0] h_index;
   logic          is_first;
   logic          is_last_k;
   logic          is_last_n;

   logic          valid_reg;
   logic          first_reg;
   logic          last_reg;
   logic [AW:0]   index_reg;

   assign sizes_zero = (size_x == '0) || (size_h == '0);

   conv_index_gen #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_index_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .size_x   (nx_reg),
      .size_h   (nh_reg),
      .n        (n),
      .x_index  (x_index),
      .h_index  (h_index),
      .is_first (is_first),
      .is_last_k(is_last_k),
      .is_last_n(is_last_n)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = sizes_zero ? FINISH : RUN;
         RUN:     if (is_last_k && is_last_n) state_next = DRAIN;
         DRAIN:   state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs and counter controls.
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      addr_x = '0;
      addr_h = '0;
      load   = 1'b0;
      step   = 1'b0;
      case (state)
         IDLE: begin
            load = start && !sizes_zero;
         end
         RUN: begin
            busy   = 1'b1;
            addr_x = x_index;
            addr_h = h_index;
            // Hold the counters on the final pair; they reload on the next start.
            step   = !(is_last_k && is_last_n);
         end
         DRAIN: begin
            busy = 1'b1;
         end
         FINISH: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Capture the run sizes when a start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nx_reg <= '0;
         nh_reg <= '0;
      end else if (state == IDLE && start) begin
         nx_reg <= size_x;
         nh_reg <= size_h;
      end
   end

   // Delay the issue tags one stage so they arrive with the ROM data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
         index_reg <= '0;
      end else if (state == RUN) begin
         valid_reg <= 1'b1;
         first_reg <= is_first;
         last_reg  <= is_last_k;
         index_reg <= n;
      end else begin
         valid_reg <= 1'b0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
         index_reg <= '0;
      end
   end

   assign pair_valid = valid_reg;
   assign pair_first = first_reg;
   assign pair_last  = last_reg;
   assign out_index  = index_reg;
   assign pair_x     = x_data;
   assign pair_h     = h_data;

endmodule
